sample_clock_meter: RTL and testbench

SAMPLE_CLOCK_METER -- requirements
Module: sample_clock_meter

---
 rtl/sample_clock_meter.sv | 117 +++++++++++
 tb/tb_sample_clock_meter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_clock_meter.sv
// +----------------------------------------------------------------------------+
// | sample_clock_meter: edge/gate synchronizer and period meter for a         |
// | generated clock that is asynchronous to CLK.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sample_clock_meter #(
  parameter int unsigned width    = 16,
  parameter int unsigned timeout  = 1000,
  parameter bit          initVal  = 1'b0,
  parameter bit          initGate = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK_VAL_IN,
  input  logic             GATE_IN,
  output logic             RISE_OUT,
  output logic             FALL_OUT,
  output logic             GATE_OUT,
  output logic             GATE_CHG_OUT,
  output logic [width-1:0] PERIOD_OUT,
  output logic             PERIOD_VALID,
  input  logic             PERIOD_READY,
  output logic             STALL_OUT,
  output logic             OVERRUN_OUT
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [width-1:0] CNT_ONE = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] CNT_MAX = {width{1'b1}};

  logic [1:0]       clk_sync_q;
  logic             clk_hist_q;
  logic [1:0]       gate_sync_q;
  logic             gate_hist_q;
  state_t           state_q;
  logic [width-1:0] cnt_q;
  logic [width-1:0] cnt_inc_d;
  logic             timeout_hit_d;

  assign GATE_OUT = gate_sync_q[1];

  // Saturating increment; the compare is done one bit wider so that a timeout
  // larger than the counter range simply never fires.
  assign cnt_inc_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign timeout_hit_d = ({{(33-width){1'b0}}, cnt_inc_d} >= {1'b0, timeout});

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync_q   <= {2{initVal}};
      clk_hist_q   <= initVal;
      gate_sync_q  <= {2{initGate}};
      gate_hist_q  <= initGate;
      RISE_OUT     <= 1'b0;
      FALL_OUT     <= 1'b0;
      GATE_CHG_OUT <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      PERIOD_OUT   <= '0;
      PERIOD_VALID <= 1'b0;
      STALL_OUT    <= 1'b0;
      OVERRUN_OUT  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], CLK_VAL_IN};
      clk_hist_q   <= clk_sync_q[1];
      gate_sync_q  <= {gate_sync_q[0], GATE_IN};
      gate_hist_q  <= gate_sync_q[1];
      RISE_OUT     <= clk_sync_q[1] & ~clk_hist_q;
      FALL_OUT     <= ~clk_sync_q[1] & clk_hist_q;
      GATE_CHG_OUT <= gate_sync_q[1] ^ gate_hist_q;

      // A capture later in this block overrides the consume.
      if (PERIOD_VALID && PERIOD_READY) begin
        PERIOD_VALID <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (RISE_OUT) begin
            STALL_OUT <= 1'b0;
            if (GATE_OUT) begin
              state_q <= ARMED;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        ARMED: begin
          if (!GATE_OUT) begin
            state_q <= IDLE;
          end else if (RISE_OUT) begin
            PERIOD_OUT   <= cnt_q;
            PERIOD_VALID <= 1'b1;
            if (PERIOD_VALID && !PERIOD_READY) begin
              OVERRUN_OUT <= 1'b1;
            end
            cnt_q <= CNT_ONE;
          end else begin
            cnt_q <= cnt_inc_d;
            if (timeout_hit_d) begin
              state_q   <= IDLE;
              STALL_OUT <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sample_clock_meter.sv
// +----------------------------------------------------------------------------+
// | tb_sample_clock_meter: vector table, directed corner sequences and random |
// | stimulus against a cycle-level behavioural model.  Revision: 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sample_clock_meter;

  localparam int W         = 16;
  localparam int TO        = 8;
  localparam int MAXC      = (1 << W) - 1;
  localparam bit INIT_VAL  = 1'b0;
  localparam bit INIT_GATE = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_val = 1'b0;
  logic gate = 1'b1;
  logic ready = 1'b1;

  logic         d1_rise, d1_fall, d1_gate, d1_chg, d1_valid, d1_stall, d1_ovr;
  logic [W-1:0] d1_per;
  logic         d2_rise, d2_fall, d2_gate, d2_chg, d2_valid, d2_stall, d2_ovr;
  logic [3:0]   d2_per;

  always #5 clk = ~clk;

  sample_clock_meter #(.width(W), .timeout(TO), .initVal(INIT_VAL), .initGate(INIT_GATE)) dut (
    .CLK(clk), .RST(rst), .CLK_VAL_IN(clk_val), .GATE_IN(gate),
    .RISE_OUT(d1_rise), .FALL_OUT(d1_fall), .GATE_OUT(d1_gate), .GATE_CHG_OUT(d1_chg),
    .PERIOD_OUT(d1_per), .PERIOD_VALID(d1_valid), .PERIOD_READY(ready),
    .STALL_OUT(d1_stall), .OVERRUN_OUT(d1_ovr)
  );

  // Narrow counter, timeout beyond its range: exercises saturation only.
  sample_clock_meter #(.width(4), .timeout(1000), .initVal(INIT_VAL), .initGate(INIT_GATE)) dut_sat (
    .CLK(clk), .RST(rst), .CLK_VAL_IN(clk_val), .GATE_IN(gate),
    .RISE_OUT(d2_rise), .FALL_OUT(d2_fall), .GATE_OUT(d2_gate), .GATE_CHG_OUT(d2_chg),
    .PERIOD_OUT(d2_per), .PERIOD_VALID(d2_valid), .PERIOD_READY(ready),
    .STALL_OUT(d2_stall), .OVERRUN_OUT(d2_ovr)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: sample history (index 0 = newest) and measurement state.
  bit xh[4];
  bit gh[4];
  bit m_rise, m_fall, m_gate, m_chg, m_val, m_stall, m_ovr, m_arm;
  int m_cnt, m_per;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit r, gt, cap;
    int capv;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        xh[i] = INIT_VAL;
        gh[i] = INIT_GATE;
      end
      m_arm = 0; m_cnt = 0; m_per = 0; m_val = 0; m_stall = 0; m_ovr = 0;
      m_rise = 0; m_fall = 0; m_chg = 0; m_gate = INIT_GATE;
      return;
    end
    r = m_rise;
    gt = m_gate;
    cap = 0;
    capv = 0;
    if (m_arm) begin
      if (!gt) m_arm = 0;
      else if (r) begin
        cap = 1; capv = m_cnt; m_cnt = 1;
      end else begin
        m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
        if (m_cnt >= TO) begin
          m_arm = 0; m_stall = 1;
        end
      end
    end else if (r) begin
      m_stall = 0;
      if (gt) begin
        m_arm = 1; m_cnt = 1;
      end
    end
    if (cap) begin
      if (m_val && !ready) m_ovr = 1;
      m_per = capv;
      m_val = 1;
    end else if (m_val && ready) begin
      m_val = 0;
    end
    for (int i = 3; i > 0; i--) begin
      xh[i] = xh[i-1];
      gh[i] = gh[i-1];
    end
    xh[0] = clk_val;
    gh[0] = gate;
    m_rise = xh[2] & !xh[3];
    m_fall = !xh[2] & xh[3];
    m_gate = gh[1];
    m_chg  = gh[2] ^ gh[3];
  endtask

  task automatic model_cmp();
    chk("model_rise", d1_rise, m_rise);
    chk("model_fall", d1_fall, m_fall);
    chk("model_gate", d1_gate, m_gate);
    chk("model_gate_chg", d1_chg, m_chg);
    chk("model_valid", d1_valid, m_val);
    chk("model_period", d1_per, m_per);
    chk("model_stall", d1_stall, m_stall);
    chk("model_overrun", d1_ovr, m_ovr);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_cmp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit x;
    bit rise;
    bit fall;
    bit valid;
    int period;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // 3-high / 2-low clock, gate open, ready high: arm on first rise, then 5.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 5};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 5};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 5};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 5};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 5};

    // Reset state
    rst = 1'b1; clk_val = 1'b0; gate = 1'b1; ready = 1'b1;
    tick();
    tick();
    chk("reset_valid", d1_valid, 0);
    chk("reset_period", d1_per, 0);
    chk("reset_gate", d1_gate, 1);
    chk("reset_stall", d1_stall, 0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      clk_val = tbl[i].x;
      tick();
      chk("tbl_rise", d1_rise, tbl[i].rise);
      chk("tbl_fall", d1_fall, tbl[i].fall);
      chk("tbl_valid", d1_valid, tbl[i].valid);
      chk("tbl_period", d1_per, tbl[i].period);
    end

    // Stall: clock stops high after arming, then recovers
    gate = 1'b1; ready = 1'b1; clk_val = 1'b0;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      clk_val = 1'b1;
      tick();
      if (e == 10) chk("stall_early", d1_stall, 0);
      if (e == 11) begin
        chk("stall_set", d1_stall, 1);
        chk("stall_nocap", d1_valid, 0);
      end
    end
    for (int c = 0; c <= 10; c++) begin
      clk_val = ((c % 5) >= 2);
      tick();
      if (c == 5) begin
        chk("stall_clear", d1_stall, 0);
        chk("stall_rearm_nocap", d1_valid, 0);
      end
      if (c == 10) begin
        chk("stall_recap_valid", d1_valid, 1);
        chk("stall_recap_period", d1_per, 5);
      end
    end

    // Overrun: captures of 5 and 7 with ready low
    gate = 1'b1; ready = 1'b0; clk_val = 1'b0;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      clk_val = (e <= 3) || (e >= 6 && e <= 8) || (e >= 13);
      tick();
      if (e == 9) chk("ovr_first", d1_per, 5);
      if (e == 16) begin
        chk("ovr_period", d1_per, 7);
        chk("ovr_valid", d1_valid, 1);
        chk("ovr_flag", d1_ovr, 1);
      end
    end
    ready = 1'b1;
    tick();
    chk("ovr_consume", d1_valid, 0);
    ready = 1'b0;
    tick();
    chk("ovr_sticky", d1_ovr, 1);

    // Gate drop while armed, then reopen
    gate = 1'b1; ready = 1'b1; clk_val = 1'b0;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      clk_val = (((e - 1) % 5) < 3);
      gate = !(e >= 6 && e <= 12);
      tick();
      if (e == 7) chk("gate_chg_before", d1_chg, 0);
      if (e == 8) chk("gate_chg_pulse", d1_chg, 1);
      if (e == 9) chk("gate_chg_after", d1_chg, 0);
      if (e < 24) chk("gate_nocap", d1_valid, 0);
      else begin
        chk("gate_cap_valid", d1_valid, 1);
        chk("gate_cap_period", d1_per, 5);
      end
    end

    // Saturation on the narrow instance, then reset mid-period
    gate = 1'b1; ready = 1'b0; clk_val = 1'b0;
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      clk_val = (((e - 1) % 20) < 10);
      tick();
      if (e == 23) chk("sat_not_yet", d2_valid, 0);
      if (e == 24) begin
        chk("sat_valid", d2_valid, 1);
        chk("sat_period", d2_per, 15);
      end
      if (e == 34) chk("sat_d1_stalled", d1_stall, 1);
    end
    rst = 1'b1;
    tick();
    chk("rst_d1_stall", d1_stall, 0);
    chk("rst_d1_gate", d1_gate, 1);
    chk("rst_d2_valid", d2_valid, 0);
    chk("rst_d2_period", d2_per, 0);
    chk("rst_d2_pulses", {d2_rise, d2_fall, d2_chg, d2_stall, d2_ovr}, 0);
    chk("rst_d2_gate", d2_gate, 1);
    rst = 1'b0;

    // Random stimulus against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) clk_val = ~clk_val;
      if ($urandom_range(0, 59) == 0) gate = ~gate;
      ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
